// File: rtl/fifo_pkg.sv
// Shared FIFO constants and the flag decode used by the top level.
// Provides default widths, the flag bundle type and fifo_flags().
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;

    typedef struct packed {
        logic full;
        logic empty;
    } flags_t;

    // Pointers arrive zero-extended; only bits [aw:0] are ever set.
    // Full means the low bits match and only the wrap bit differs.
    function automatic flags_t fifo_flags(
        input logic [31:0] wp,
        input logic [31:0] rp,
        input int unsigned aw
    );
        flags_t f;
        f.empty = (wp == rp);
        f.full  = ((wp ^ rp) == (32'd1 << aw));
        return f;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array with a registered read port.
// Ports: clk, rst_n, we/waddr/wdata (write), re/raddr/rdata (read).
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO: pointers, full/empty flags and accept gating.
// Ports: clk, rst_n, wr_en, rd_en, din -> dout, full, empty.
module async_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH:0] wr_ptr;
    logic [ADDR_WIDTH:0] rd_ptr;
    flags_t              flags;
    logic                wr_ok;
    logic                rd_ok;

    // Flags decode straight from registered pointers.
    assign flags = fifo_flags(32'(wr_ptr), 32'(rd_ptr), ADDR_WIDTH);
    assign full  = flags.full;
    assign empty = flags.empty;

    assign wr_ok = wr_en && !flags.full;
    assign rd_ok = rd_en && !flags.empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_ok),
        .waddr(wr_ptr[ADDR_WIDTH-1:0]),
        .wdata(din),
        .re   (rd_ok),
        .raddr(rd_ptr[ADDR_WIDTH-1:0]),
        .rdata(dout)
    );

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo against a queue reference model.
// Directed test-plan phases followed by randomized traffic.
module tb_async_fifo;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full;
    logic          empty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;

    async_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wr_en(wr_en),
        .rd_en(rd_en),
        .din  (din),
        .dout (dout),
        .full (full),
        .empty(empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".dout"}, 32'(dout), 32'(exp_dout));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    endtask

    // One clock: drive, model the edge, then check after it.
    task automatic cycle(input logic w, input logic r,
                         input logic [DW-1:0] d, input string tag);
        bit wok;
        bit rok;
        wr_en = w;
        rd_en = r;
        din   = d;
        wok   = w && (q.size() < DEPTH);
        rok   = r && (q.size() > 0);
        @(posedge clk);
        #1;
        if (rok) exp_dout = q.pop_front();
        if (wok) q.push_back(d);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        q.delete();
        exp_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_state("reset");
    endtask

    initial begin
        int pw;
        int pr;
        logic [DW-1:0] v;
        rst_n = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        exp_dout = '0;

        do_reset();

        for (int i = 0; i < 20; i++)
            cycle(1'b1, 1'b0, DW'(i + 1), "fill");
        for (int i = 0; i < 20; i++)
            cycle(1'b0, 1'b1, '0, "drain");

        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, DW'(8'h40 + i), "half");
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 1'b1, DW'(8'h50 + i), "simul");
        for (int i = 0; i < 8; i++)
            cycle(1'b0, 1'b1, '0, "simul_drain");

        for (int i = 0; i < DEPTH; i++)
            cycle(1'b1, 1'b0, DW'(8'h60 + i), "to_full");
        cycle(1'b1, 1'b1, 8'hee, "full_both");
        while (q.size() > 0)
            cycle(1'b0, 1'b1, '0, "full_drain");
        cycle(1'b1, 1'b1, 8'h77, "empty_both");
        cycle(1'b0, 1'b1, '0, "empty_read");

        v = 8'h80;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                cycle(1'b1, 1'b0, v, "wrap_fill");
                v = v + 1'b1;
            end
            for (int i = 0; i < DEPTH; i++)
                cycle(1'b0, 1'b1, '0, "wrap_drain");
        end

        for (int i = 0; i < 5; i++)
            cycle(1'b1, 1'b0, DW'(8'hc0 + i), "pre_rst");
        cycle(1'b0, 1'b1, '0, "pre_rst_rd");
        #1;
        rst_n = 1'b0;
        q.delete();
        exp_dout = '0;
        #1;
        check_state("mid_rst");
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h5a, "post_rst_wr");
        cycle(1'b0, 1'b1, '0, "post_rst_rd");

        for (int blk = 0; blk < 8; blk++) begin
            pw = 20 + int'($urandom_range(70));
            pr = 20 + int'($urandom_range(70));
            for (int i = 0; i < 50; i++)
                cycle(($urandom_range(99) < pw), ($urandom_range(99) < pr),
                      DW'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
